// File: rtl/gauss_conv_sequencer_if.sv
// Tap command channel from the convolution sequencer to the MAC/accumulator.
// The sequencer drives the master side and the datapath returns tap_ready.
interface gauss_conv_sequencer_if #(
  parameter int AW = 16,
  parameter int KW = 8
);
  logic          tap_valid;
  logic          tap_ready;
  logic [AW-1:0] tap_addr;
  logic [KW-1:0] tap_kidx;
  logic          tap_mask;
  logic          tap_first;
  logic          tap_last;

  modport master (
    output tap_valid, tap_addr, tap_kidx, tap_mask, tap_first, tap_last,
    input  tap_ready
  );

  modport slave (
    input  tap_valid, tap_addr, tap_kidx, tap_mask, tap_first, tap_last,
    output tap_ready
  );
endinterface

// File: rtl/gauss_conv_sequencer.sv
// Frame sequencer for the Gaussian convolution datapath: walks output pixels in raster
// order and issues one registered tap command per accepted beat.
module gauss_conv_sequencer #(
  parameter int ROWS  = 168,
  parameter int COLS  = 220,
  parameter int KSIZE = 5,
  parameter int AW    = 16,
  parameter int KW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            out_row,
  output logic [15:0]            out_col,
  gauss_conv_sequencer_if.master tap
);
  localparam int C    = KSIZE / 2;
  localparam int KK   = KSIZE * KSIZE;
  localparam int MAXD = (ROWS > COLS) ? ROWS : COLS;
  localparam int CW   = $clog2(MAXD + KSIZE) + 2;
  localparam int BW   = $clog2((ROWS + KSIZE) * COLS) + 2;

  localparam logic signed [CW-1:0] ONE    = CW'(1);
  localparam logic signed [CW-1:0] CPOS   = CW'(C);
  localparam logic signed [CW-1:0] CNEG   = -CPOS;
  localparam logic signed [CW-1:0] ROWS_S = CW'(ROWS);
  localparam logic signed [CW-1:0] COLS_S = CW'(COLS);
  localparam logic signed [BW-1:0] COLS_B = BW'(COLS);
  localparam logic signed [BW-1:0] BASE0  = BW'(C * COLS);
  localparam logic [KW-1:0]        KIDX0  = KW'(KK - 1);
  localparam logic [15:0]          LAST_ROW = 16'(ROWS - 1);
  localparam logic [15:0]          LAST_COL = 16'(COLS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state_reg, state_next;

  logic [15:0]          i_reg, j_reg, i_next, j_next;
  logic signed [CW-1:0] k_reg, l_reg, y_reg, z_reg;
  logic signed [CW-1:0] k_next, l_next, y_next, z_next;
  logic signed [BW-1:0] ybase_reg, ibase_reg, ybase_next, ibase_next;
  logic [KW-1:0]        kidx_reg, kidx_next;
  logic [AW-1:0]        addr_reg, addr_next;
  logic [BW-1:0]        lin_next;
  logic                 mask_reg, mask_next;
  logic                 first_reg, last_reg, valid_reg, busy_reg, done_reg;
  logic                 load, advance, accept, pixel_end, frame_end;

  assign accept    = valid_reg & tap.tap_ready;
  assign pixel_end = (k_reg == CNEG) && (l_reg == CNEG);
  assign frame_end = pixel_end && (i_reg == LAST_ROW) && (j_reg == LAST_COL);

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    advance    = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          load       = 1'b1;
        end
      end
      RUN: begin
        if (accept) begin
          if (frame_end) state_next = DONE;
          else           advance    = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next tap: l steps fastest, then k, then the pixel. ybase tracks y*COLS without a multiply.
  always_comb begin
    i_next     = i_reg;
    j_next     = j_reg;
    k_next     = k_reg;
    l_next     = l_reg;
    y_next     = y_reg;
    z_next     = z_reg;
    ybase_next = ybase_reg;
    ibase_next = ibase_reg;
    kidx_next  = kidx_reg;
    if (load) begin
      i_next     = '0;
      j_next     = '0;
      k_next     = CPOS;
      l_next     = CPOS;
      y_next     = CPOS;
      z_next     = CPOS;
      ybase_next = BASE0;
      ibase_next = BASE0;
      kidx_next  = KIDX0;
    end else if (advance) begin
      kidx_next = kidx_reg - KW'(1);
      if (l_reg != CNEG) begin
        l_next = l_reg - ONE;
        z_next = z_reg - ONE;
      end else if (k_reg != CNEG) begin
        k_next     = k_reg - ONE;
        l_next     = CPOS;
        y_next     = y_reg - ONE;
        z_next     = $signed(CW'(j_reg)) + CPOS;
        ybase_next = ybase_reg - COLS_B;
      end else begin
        k_next    = CPOS;
        l_next    = CPOS;
        kidx_next = KIDX0;
        if (j_reg == LAST_COL) begin
          j_next     = '0;
          i_next     = i_reg + 16'd1;
          ibase_next = ibase_reg + COLS_B;
        end else begin
          j_next = j_reg + 16'd1;
        end
        y_next     = $signed(CW'(i_next)) + CPOS;
        z_next     = $signed(CW'(j_next)) + CPOS;
        ybase_next = ibase_next;
      end
    end
    mask_next = !y_next[CW-1] && (y_next < ROWS_S) && !z_next[CW-1] && (z_next < COLS_S);
    lin_next  = ybase_next + BW'(z_next);
    addr_next = mask_next ? AW'(lin_next) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      valid_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      i_reg     <= '0;
      j_reg     <= '0;
      k_reg     <= '0;
      l_reg     <= '0;
      y_reg     <= '0;
      z_reg     <= '0;
      ybase_reg <= '0;
      ibase_reg <= '0;
      kidx_reg  <= '0;
      addr_reg  <= '0;
      mask_reg  <= 1'b0;
      first_reg <= 1'b0;
      last_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= (state_next == RUN);
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      // Tap registers only move on load or acceptance, so a stall holds every output.
      if (load || advance) begin
        i_reg     <= i_next;
        j_reg     <= j_next;
        k_reg     <= k_next;
        l_reg     <= l_next;
        y_reg     <= y_next;
        z_reg     <= z_next;
        ybase_reg <= ybase_next;
        ibase_reg <= ibase_next;
        kidx_reg  <= kidx_next;
        addr_reg  <= addr_next;
        mask_reg  <= mask_next;
        first_reg <= (k_next == CPOS) && (l_next == CPOS);
        last_reg  <= (k_next == CNEG) && (l_next == CNEG);
      end
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign out_row       = i_reg;
  assign out_col       = j_reg;
  assign tap.tap_valid = valid_reg;
  assign tap.tap_addr  = addr_reg;
  assign tap.tap_kidx  = kidx_reg;
  assign tap.tap_mask  = mask_reg;
  assign tap.tap_first = first_reg;
  assign tap.tap_last  = last_reg;
endmodule

// File: doc/gauss_conv_sequencer.md
Name: gauss_conv_sequencer

Overview:
- Frame-level controller for the Gaussian convolution datapath.
- Walks output pixels in raster order. For each pixel it steps through every kernel tap and issues one tap command per beat: image-memory read address, kernel coefficient index and in-bounds mask.
- Uses a valid/ready handshake with the downstream MAC/accumulator.
- Frames first/last tap of each pixel so the datapath can clear its sum, then divide by 4096 and emit the result.

Parameters:
- ROWS, 168, image height in pixels.
- COLS, 220, image width in pixels.
- KSIZE, 5, kernel edge length; odd, 3..15.
- AW, 16, tap_addr width; must satisfy 2^AW >= ROWS*COLS.
- KW, 8, tap_kidx width; must satisfy 2^KW >= KSIZE*KSIZE.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle frame start request.
- busy  out  1  high while a frame is in progress.
- done  out  1  one-cycle pulse after the final tap of the frame is accepted.
- tap_valid  out  1  tap command valid.
- tap_ready  in  1  datapath accepts the tap.
- tap_addr  out  AW  linear pixel address (y*COLS+z); 0 when tap_mask=0.
- tap_kidx  out  KW  kernel index (c+k)*KSIZE+(c+l), with c=KSIZE/2.
- tap_mask  out  1  1 = tap inside the image; 0 = tap contributes zero.
- tap_first  out  1  first tap of the current output pixel.
- tap_last  out  1  last tap of the current output pixel.
- out_row  out  16  row i of the pixel being computed.
- out_col  out  16  column j of the pixel being computed.

Behaviour:
- Reset: FSM to IDLE. busy, done, tap_valid, tap_mask, tap_first and tap_last = 0; tap_addr, tap_kidx, out_row and out_col = 0. All counters cleared.
- Reset mid-frame: same result on the next edge. The in-flight tap is dropped and done is not pulsed.
- States: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
  - RUN -> DONE on acceptance (tap_valid & tap_ready) of the last tap of pixel (ROWS-1, COLS-1).
  - DONE -> IDLE unconditionally after one cycle.
- Outputs by state:
  - busy=1 in RUN and DONE.
  - done=1 only in DONE.
  - tap_valid=1 for every cycle in RUN, and 0 otherwise.
- start while busy is ignored. A start sampled in DONE is also ignored.
- Latency: start sampled at edge t gives tap_valid=1 from edge t+1. The first beat is the first tap of pixel (0,0).
- Tap order per pixel:
  - Outer k runs from +c down to -c; inner l runs from +c down to -c.
  - y=i+k, z=j+l.
  - This gives KSIZE*KSIZE beats per pixel; tap_kidx goes from KSIZE*KSIZE-1 down to 0.
  - tap_first=1 when k=l=+c; tap_last=1 when k=l=-c.
- Pixel order: j increments after a tap_last beat is accepted. On wrap j -> 0, i increments.
- Boundary handling:
  - tap_mask=1 iff 0<=y<ROWS and 0<=z<COLS.
  - Out-of-bounds taps are still issued, with mask=0 and addr=0, so beat count is fixed.
  - Every frame is exactly ROWS*COLS*KSIZE*KSIZE accepted beats.
- Stall: while tap_valid=1 and tap_ready=0, all tap_* outputs and out_row/out_col hold stable. Counters advance only on acceptance.
- Back-to-back: with tap_ready tied high, one tap is issued per cycle with no bubbles between pixels.
- Arithmetic:
  - Internal y and z are signed, wide enough for -c .. max(ROWS,COLS)-1+c.
  - tap_addr must be derived incrementally (row base += COLS), not by a combinational multiply.
  - All outputs are registered.
- out_row/out_col equal (i,j) for every beat of that pixel, including its tap_last beat.

Test Plan:
1. ROWS=4, COLS=5, KSIZE=3, tap_ready=1, start pulse -> pixel (0,0) beats are:
   - beat 1: addr 6, kidx 8, mask 1, first 1
   - beat 2: addr 5, kidx 7, mask 1
   - beat 3: kidx 6, mask 0, addr 0
   - beat 9: kidx 0, mask 0, last 1
2. Same config, run to end -> exactly 180 accepted beats. Last beat has out_row=3, out_col=4, kidx 0, mask 1, addr 13. done=1 on the next cycle only, then busy=0.
3. Pixel (3,4) first beat (y=4, z=5) -> mask 0, addr 0. Pixel (2,3) beat kidx 4 -> addr 13, mask 1.
4. Hold tap_ready=0 for 3 cycles mid-pixel -> all tap_* and out_row/out_col stay unchanged. The next accepted beat resumes with the following kidx, and the total beat count is still 180.
5. Assert start again during RUN -> ignored, frame length unchanged. Assert rst at beat 50 -> next cycle tap_valid=0, busy=0, no done pulse. A new start restarts at pixel (0,0), kidx 8.
6. Default parameters (168x220, KSIZE=5), tap_ready randomly toggled -> accepted beats = 924000. Masked-sum model matches a golden software convolution (sum/4096) on every pixel.
